// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Moore control word produced by the main FSM for the current state
  typedef struct packed {
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
  } ctrl_t;

  function automatic logic [2:0] imm_decode(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_I: imm_decode = IMM_I;
      OP_STORE:      imm_decode = IMM_S;
      OP_BRANCH:     imm_decode = IMM_B;
      OP_JAL:        imm_decode = IMM_J;
      default:       imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, selects/enables out.
interface mc_if;
  import mc_pkg::*;

  logic [OP_W-1:0]    op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic [2:0]         immsrc;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic [1:0]         resultsrc;
  logic               adrsrc;
  logic               irwrite;
  logic               pcwrite;
  logic               regwrite;
  logic               memwrite;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
           irwrite, pcwrite, regwrite, memwrite, illegal, state_o
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
           irwrite, pcwrite, regwrite, memwrite, illegal, state_o
  );
endinterface

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: maps aluop and instruction fields to an ALU function.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol_c
);

  always_comb begin
    alucontrol_c = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol_c = ALU_ADD;
      ALUOP_SUB: alucontrol_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op5=1) with funct7b5 selects sub; addi ignores funct7
          3'b000:  alucontrol_c = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_c = ALU_SLT;
          3'b110:  alucontrol_c = ALU_OR;
          3'b111:  alucontrol_c = ALU_AND;
          default: alucontrol_c = ALU_ADD;
        endcase
      end
      default: alucontrol_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RISC-V control unit: Moore main FSM, immediate select and ALU decode.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t state;
  state_t state_nxt;
  state_t state_dec;
  ctrl_t  ctl;
  logic   illegal_dec;
  logic   taken;
  logic   bne_en;

  assign bne_en = SUPPORT_BNE;

  // Selects follow the FETCH decode for as long as reset is held
  assign state_dec = reset ? S_FETCH : state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    ctl         = '0;
    state_nxt   = S_FETCH;
    illegal_dec = 1'b0;
    case (state_dec)
      S_FETCH: begin
        ctl.irwrite   = 1'b1;
        ctl.alusrca   = SRCA_PC;
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALURESULT;
        ctl.pcupdate  = 1'b1;
        state_nxt     = S_DECODE;
      end
      S_DECODE: begin
        ctl.alusrca = SRCA_OLDPC;
        ctl.alusrcb = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH: begin
            if (bne_en || (bus.funct3 == 3'b000)) state_nxt = S_BRANCH;
            else                                  illegal_dec = 1'b1;
          end
          default: illegal_dec = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctl.alusrca = SRCA_RS1;
        ctl.alusrcb = SRCB_IMM;
        state_nxt   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.resultsrc = RES_ALUOUT;
        ctl.adrsrc    = 1'b1;
        state_nxt     = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.resultsrc = RES_DATA;
        ctl.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.resultsrc = RES_ALUOUT;
        ctl.adrsrc    = 1'b1;
        ctl.memwrite  = 1'b1;
      end
      S_EXECR: begin
        ctl.alusrca = SRCA_RS1;
        ctl.alusrcb = SRCB_RS2;
        ctl.aluop   = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.resultsrc = RES_ALUOUT;
        ctl.regwrite  = 1'b1;
      end
      S_EXECI: begin
        ctl.alusrca = SRCA_RS1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_JAL: begin
        ctl.alusrca   = SRCA_OLDPC;
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALUOUT;
        ctl.pcupdate  = 1'b1;
        state_nxt     = S_ALUWB;
      end
      S_BRANCH: begin
        ctl.alusrca   = SRCA_RS1;
        ctl.alusrcb   = SRCB_RS2;
        ctl.aluop     = ALUOP_SUB;
        ctl.resultsrc = RES_ALUOUT;
        ctl.branch    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop        (ctl.aluop),
    .funct3       (bus.funct3),
    .op5          (bus.op[5]),
    .funct7b5     (bus.funct7b5),
    .alucontrol_c (bus.alucontrol)
  );

  // bne inverts the sense of zero when enabled
  assign taken = bus.zero ^ (bne_en & bus.funct3[0]);

  assign bus.immsrc    = imm_decode(bus.op);
  assign bus.alusrca   = ctl.alusrca;
  assign bus.alusrcb   = ctl.alusrcb;
  assign bus.resultsrc = ctl.resultsrc;
  assign bus.adrsrc    = ctl.adrsrc;
  assign bus.irwrite   = ctl.irwrite & ~reset;
  assign bus.pcwrite   = (ctl.pcupdate | (ctl.branch & taken)) & ~reset;
  assign bus.regwrite  = ctl.regwrite & ~reset;
  assign bus.memwrite  = ctl.memwrite & ~reset;
  assign bus.illegal   = illegal_dec & ~reset;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller plus reset-abort sequences.
module tb_mc_controller;

  logic clk;
  logic reset;

  mc_if bus();

  mc_controller #(.SUPPORT_BNE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // enables {irwrite, pcwrite, regwrite, memwrite, illegal}
  localparam logic [4:0] EN_F  = 5'b11000;
  localparam logic [4:0] EN_0  = 5'b00000;
  localparam logic [4:0] EN_RW = 5'b00100;
  localparam logic [4:0] EN_MW = 5'b00010;
  localparam logic [4:0] EN_PC = 5'b01000;
  localparam logic [4:0] EN_IL = 5'b00001;

  // selects {alusrca, alusrcb, resultsrc, adrsrc}
  localparam logic [6:0] SL_F  = 7'b00_10_10_0;
  localparam logic [6:0] SL_D  = 7'b01_01_00_0;
  localparam logic [6:0] SL_MA = 7'b10_01_00_0;
  localparam logic [6:0] SL_MR = 7'b00_00_00_1;
  localparam logic [6:0] SL_WB = 7'b00_00_01_0;
  localparam logic [6:0] SL_MW = 7'b00_00_00_1;
  localparam logic [6:0] SL_ER = 7'b10_00_00_0;
  localparam logic [6:0] SL_AW = 7'b00_00_00_0;
  localparam logic [6:0] SL_EI = 7'b10_01_00_0;
  localparam logic [6:0] SL_J  = 7'b01_10_00_0;
  localparam logic [6:0] SL_BR = 7'b10_00_00_0;

  typedef struct packed {
    logic [6:0]         op;
    logic [2:0]         f3;
    logic               f7;
    logic               zero;
    logic [2:0]         n;
    logic [0:5][3:0]    st;
    logic [0:5][4:0]    en;
    logic [0:5][6:0]    sel;
    logic [2:0]         imm;
    logic [2:0]         alu;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int passed;
  int total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    bus.op       = v.op;
    bus.funct3   = v.f3;
    bus.funct7b5 = v.f7;
    bus.zero     = v.zero;
    for (int c = 0; c < int'(v.n); c++) begin
      #1;
      chk($sformatf("v%0d c%0d state", i, c), 32'(bus.state_o), 32'(v.st[c]));
      chk($sformatf("v%0d c%0d enables", i, c),
          32'({bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.illegal}), 32'(v.en[c]));
      chk($sformatf("v%0d c%0d selects", i, c),
          32'({bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc}), 32'(v.sel[c]));
      chk($sformatf("v%0d c%0d immsrc", i, c), 32'(bus.immsrc), 32'(v.imm));
      chk($sformatf("v%0d c%0d alucontrol", i, c), 32'(bus.alucontrol),
          (c == 2) ? 32'(v.alu) : 32'(3'b000));
      @(negedge clk);
    end
    #1;
    chk($sformatf("v%0d return state", i), 32'(bus.state_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    passed = 0;
    total  = 0;

    //              op           f3      f7    z     n     states                                   enables                                  selects                                    imm     alu
    vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 3'd5, {4'd0,4'd1,4'd2,4'd3,4'd4,4'd0}, {EN_F,EN_0,EN_0,EN_0,EN_RW,EN_0}, {SL_F,SL_D,SL_MA,SL_MR,SL_WB,SL_AW}, 3'b000, 3'b000};
    vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd2,4'd5,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_MW,EN_0,EN_0}, {SL_F,SL_D,SL_MA,SL_MW,SL_AW,SL_AW}, 3'b001, 3'b000};
    vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 3'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_ER,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b001};
    vecs[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_ER,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b000};
    vecs[4]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 3'd4, {4'd0,4'd1,4'd8,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_EI,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b000};
    vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_ER,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b011};
    vecs[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_ER,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b010};
    vecs[7]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_ER,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b101};
    vecs[8]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0}, {EN_F,EN_0,EN_PC,EN_0,EN_0,EN_0}, {SL_F,SL_D,SL_BR,SL_AW,SL_AW,SL_AW}, 3'b010, 3'b001};
    vecs[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_0,EN_0,EN_0}, {SL_F,SL_D,SL_BR,SL_AW,SL_AW,SL_AW}, 3'b010, 3'b001};
    vecs[10] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0}, {EN_F,EN_0,EN_PC,EN_0,EN_0,EN_0}, {SL_F,SL_D,SL_BR,SL_AW,SL_AW,SL_AW}, 3'b010, 3'b001};
    vecs[11] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3'd3, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_0,EN_0,EN_0}, {SL_F,SL_D,SL_BR,SL_AW,SL_AW,SL_AW}, 3'b010, 3'b001};
    vecs[12] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 3'd4, {4'd0,4'd1,4'd9,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_PC,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_J,SL_AW,SL_AW,SL_AW}, 3'b011, 3'b000};
    vecs[13] = '{7'b1110011, 3'b000, 1'b0, 1'b0, 3'd2, {4'd0,4'd1,4'd0,4'd0,4'd0,4'd0}, {EN_F,EN_IL,EN_0,EN_0,EN_0,EN_0}, {SL_F,SL_D,SL_AW,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b000};
    vecs[14] = '{7'b0010011, 3'b100, 1'b1, 1'b0, 3'd4, {4'd0,4'd1,4'd8,4'd7,4'd0,4'd0}, {EN_F,EN_0,EN_0,EN_RW,EN_0,EN_0}, {SL_F,SL_D,SL_EI,SL_AW,SL_AW,SL_AW}, 3'b000, 3'b000};

    // Reset held for two edges with an R-type in the IR
    reset        = 1'b1;
    bus.op       = 7'b0110011;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", 32'(bus.state_o), 32'd0);
    chk("reset enables", 32'({bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.illegal}), 32'd0);
    chk("reset selects", 32'({bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc}), 32'(SL_F));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset arriving in MEMWRITE must suppress the store and abort to FETCH
    bus.op     = 7'b0100011;
    bus.funct3 = 3'b010;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort sw state", 32'(bus.state_o), 32'd5);
    chk("abort sw memwrite", 32'(bus.memwrite), 32'd0);
    chk("abort sw enables", 32'({bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.illegal}), 32'd0);
    chk("abort sw selects", 32'({bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc}), 32'(SL_F));
    @(negedge clk);
    #1;
    chk("abort sw next state", 32'(bus.state_o), 32'd0);
    reset = 1'b0;

    // Reset arriving in MEMWB must suppress the register write
    bus.op = 7'b0000011;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort lw state", 32'(bus.state_o), 32'd4);
    chk("abort lw regwrite", 32'(bus.regwrite), 32'd0);
    @(negedge clk);
    #1;
    chk("abort lw next state", 32'(bus.state_o), 32'd0);
    reset = 1'b0;

    // Normal operation resumes after the abort
    run_vec(0);
    run_vec(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
